// File: rtl/sram_req_arbiter_pkg.sv
// rtl/sram_req_arbiter_pkg.sv - shared encodings for the sram-like request arbiter
package sram_req_arbiter_pkg;

  localparam logic [1:0] SZ_1B = 2'd0;
  localparam logic [1:0] SZ_2B = 2'd1;
  localparam logic [1:0] SZ_4B = 2'd2;

  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_HOLD_I = 2'd1,
    ST_HOLD_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_req_arbiter_arb_id_fifo.sv
// rtl/sram_req_arbiter_arb_id_fifo.sv - in-order owner ID queue for accepted transactions
module arb_id_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] ids;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Push and pop are gated upstream by full/empty, so no guards here.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ids    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        ids[wr_ptr] <= push_id;
        wr_ptr      <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = ids[rd_ptr];

endmodule

// File: rtl/sram_req_arbiter.sv
// rtl/sram_req_arbiter.sv - shares one sram-like port between inst and data requesters
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2,
  parameter bit DATA_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_stray_data_ok
);

  arb_state_e state, state_nxt;
  logic       grant_inst, grant_data;
  logic       full, empty, head;
  logic       handshake, pop;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // A held grant follows only its own master; dropping req releases the lock.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    state_nxt  = ST_ARB;
    unique case (state)
      ST_ARB: begin
        if (!full) begin
          if (inst_sram_req && data_sram_req) begin
            grant_data = DATA_FIRST;
            grant_inst = !DATA_FIRST;
          end else begin
            grant_inst = inst_sram_req;
            grant_data = data_sram_req;
          end
        end
      end
      ST_HOLD_I: grant_inst = inst_sram_req;
      ST_HOLD_D: grant_data = data_sram_req;
      default:   ;
    endcase
    if (grant_inst && !mem_addr_ok) begin
      state_nxt = ST_HOLD_I;
    end else if (grant_data && !mem_addr_ok) begin
      state_nxt = ST_HOLD_D;
    end
  end

  assign mem_req   = (grant_inst || grant_data) && !full && resetn;
  assign mem_wr    = grant_inst ? inst_sram_wr    : data_sram_wr;
  assign mem_size  = grant_inst ? inst_sram_size  : data_sram_size;
  assign mem_wstrb = grant_inst ? inst_sram_wstrb : data_sram_wstrb;
  assign mem_addr  = grant_inst ? inst_sram_addr  : data_sram_addr;
  assign mem_wdata = grant_inst ? inst_sram_wdata : data_sram_wdata;

  assign handshake         = mem_req && mem_addr_ok;
  assign inst_sram_addr_ok = handshake && grant_inst;
  assign data_sram_addr_ok = handshake && grant_data;

  // Pop reads the head before this cycle's push lands, so a same-cycle return maps to an older ID.
  assign pop               = mem_data_ok && !empty && resetn;
  assign inst_sram_data_ok = pop && (head == ID_INST);
  assign data_sram_data_ok = pop && (head == ID_DATA);
  assign inst_sram_rdata   = mem_rdata;
  assign data_sram_rdata   = mem_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      err_stray_data_ok <= 1'b0;
    end else if (mem_data_ok && empty) begin
      err_stray_data_ok <= 1'b1;
    end
  end

  arb_id_fifo #(
    .DEPTH(OUTSTANDING)
  ) u_id_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (handshake),
    .push_id(grant_data ? ID_DATA : ID_INST),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb/tb_sram_req_arbiter.sv - scoreboard bench for sram_req_arbiter with a queue-based reference model
module tb_sram_req_arbiter;

  localparam int OUT = 2;
  localparam bit DF  = 1'b1;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq, iwr, dreq, dwr;
  logic [1:0]  isize, dsize;
  logic [3:0]  iwstrb, dwstrb;
  logic [31:0] iaddr, iwdata, daddr, dwdata;
  logic        i_addr_ok, i_data_ok, d_addr_ok, d_data_ok;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_stray;

  sram_req_arbiter #(.OUTSTANDING(OUT), .DATA_FIRST(DF)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(ireq), .inst_sram_wr(iwr), .inst_sram_size(isize), .inst_sram_wstrb(iwstrb),
    .inst_sram_addr(iaddr), .inst_sram_wdata(iwdata), .inst_sram_addr_ok(i_addr_ok),
    .inst_sram_data_ok(i_data_ok), .inst_sram_rdata(i_rdata),
    .data_sram_req(dreq), .data_sram_wr(dwr), .data_sram_size(dsize), .data_sram_wstrb(dwstrb),
    .data_sram_addr(daddr), .data_sram_wdata(dwdata), .data_sram_addr_ok(d_addr_ok),
    .data_sram_data_ok(d_data_ok), .data_sram_rdata(d_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .err_stray_data_ok(err_stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    bit          owner;
    logic [31:0] rdata;
  } ret_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ret_t sb[$];
  bit   mq[$];
  int   hold = 0;
  bit   exp_stray = 1'b0;
  bit   hs_i, hs_d, pend_i, pend_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic idle();
    ireq = 1'b0; dreq = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
  endtask

  // Model: grant from the rules, in-order owner queue, lock until accepted.
  task automatic run_cycle();
    int g;
    bit hs;
    cyc++;
    g = 0;
    if (hold == 1) g = ireq ? 1 : 0;
    else if (hold == 2) g = dreq ? 2 : 0;
    else if (mq.size() < OUT) begin
      if (ireq && dreq) g = DF ? 2 : 1;
      else if (ireq) g = 1;
      else if (dreq) g = 2;
    end
    hs = (g != 0) && mem_addr_ok;
    if (mem_data_ok && mq.size() > 0) sb.push_back('{cyc, mq[0], mem_rdata});
    @(negedge clk);
    chk("mem_req", 32'(mem_req), 32'(g != 0));
    if (g == 1) begin
      chk("mem_addr_i", mem_addr, iaddr);
      chk("mem_fields_i", {mem_wdata[15:0], 7'd0, mem_wr, mem_size, mem_wstrb}, {iwdata[15:0], 7'd0, iwr, isize, iwstrb});
    end else if (g == 2) begin
      chk("mem_addr_d", mem_addr, daddr);
      chk("mem_fields_d", {mem_wdata[15:0], 7'd0, mem_wr, mem_size, mem_wstrb}, {dwdata[15:0], 7'd0, dwr, dsize, dwstrb});
    end
    chk("addr_ok", {i_addr_ok, d_addr_ok}, {hs && g == 1, hs && g == 2});
    chk("err_stray", 32'(err_stray), 32'(exp_stray));
    if (mem_data_ok) begin
      if (mq.size() > 0) void'(mq.pop_front());
      else exp_stray = 1'b1;
    end
    if (hs) mq.push_back(g == 2);
    hold = (g != 0 && !mem_addr_ok) ? g : 0;
    hs_i = hs && g == 1;
    hs_d = hs && g == 2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_outputs", {mem_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, err_stray}, 0);
    mq.delete();
    sb.delete();
    hold = 0; exp_stray = 1'b0; pend_i = 1'b0; pend_d = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();
  endtask

  always @(negedge clk) begin
    if (i_data_ok || d_data_ok) begin
      ret_t r;
      chk("single_data_ok", 32'(i_data_ok && d_data_ok), 0);
      if (sb.size() == 0) begin
        chk("unexpected_data_ok", {i_data_ok, d_data_ok}, 0);
      end else begin
        r = sb.pop_front();
        chk("ret_cycle", cyc, r.cyc);
        chk("ret_owner", {i_data_ok, d_data_ok}, r.owner ? 2'b01 : 2'b10);
        chk("ret_rdata", r.owner ? d_rdata : i_rdata, r.rdata);
      end
    end
  end

  initial begin
    iwr = 1'b0; isize = 2'd2; iwstrb = 4'h0; iaddr = '0; iwdata = '0;
    dwr = 1'b0; dsize = 2'd2; dwstrb = 4'h0; daddr = '0; dwdata = '0;
    pend_i = 1'b0; pend_d = 1'b0;
    idle();
    ireq = 1'b1; dreq = 1'b1; mem_data_ok = 1'b1;
    #1;
    chk("reset_state", {mem_req, i_addr_ok, d_addr_ok, i_data_ok, d_data_ok, err_stray}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    idle();

    // Single inst read, return two cycles later.
    iaddr = 32'h1C00_0000; ireq = 1'b1; mem_addr_ok = 1'b1; run_cycle();
    idle(); run_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0000; run_cycle();

    // Simultaneous requests: data first, then inst; returns D then I.
    idle();
    ireq = 1'b1; dreq = 1'b1; dwr = 1'b1; daddr = 32'h1C00_1000; dwstrb = 4'hF; dwdata = 32'hCAFE_0001;
    mem_addr_ok = 1'b1; run_cycle();
    dreq = 1'b0; run_cycle();
    idle(); mem_data_ok = 1'b1; mem_rdata = 32'h1111_1111; run_cycle();
    mem_data_ok = 1'b1; mem_rdata = 32'h2222_2222; run_cycle();

    // Inst held while addr_ok low; data arrives mid-wait and must wait.
    idle(); ireq = 1'b1; run_cycle();
    dreq = 1'b1; run_cycle();
    run_cycle();
    mem_addr_ok = 1'b1; run_cycle();
    ireq = 1'b0; run_cycle();
    idle(); mem_data_ok = 1'b1; mem_rdata = 32'h3333_3333; run_cycle();
    mem_rdata = 32'h4444_4444; run_cycle();

    // Full queue blocks a grant even with a same-cycle pop.
    idle(); ireq = 1'b1; dreq = 1'b1; mem_addr_ok = 1'b1; run_cycle();
    dreq = 1'b0; run_cycle();
    ireq = 1'b0; dreq = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h5555_5555; run_cycle();
    mem_data_ok = 1'b0; run_cycle();
    idle(); mem_data_ok = 1'b1; mem_rdata = 32'h6666_6666; run_cycle();
    mem_rdata = 32'h7777_7777; run_cycle();

    // Issue and return in the same cycle with one older data request pending.
    idle(); dreq = 1'b1; mem_addr_ok = 1'b1; run_cycle();
    dreq = 1'b0; ireq = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h8888_8888; run_cycle();
    ireq = 1'b0; mem_rdata = 32'h9999_9999; run_cycle();

    // Stray return, sticky flag, then reset mid-transaction.
    idle(); mem_data_ok = 1'b1; run_cycle();
    idle(); run_cycle();
    run_cycle();
    dreq = 1'b1; run_cycle();
    ireq = 1'b1; dreq = 1'b1; mem_data_ok = 1'b1; mem_addr_ok = 1'b1;
    do_reset();
    idle(); mem_data_ok = 1'b1; run_cycle();
    do_reset();

    for (int i = 0; i < 1500; i++) begin
      if (i == 750) do_reset();
      if (!pend_i && $urandom_range(2) == 0) begin
        pend_i = 1'b1; iaddr = $urandom & 32'hFFFF_FFFC; iwdata = $urandom;
        iwr = 1'b0; isize = 2'd2; iwstrb = 4'($urandom);
      end
      if (!pend_d && $urandom_range(2) == 0) begin
        pend_d = 1'b1; daddr = $urandom; dwdata = $urandom;
        dwr = 1'($urandom_range(1)); dsize = 2'($urandom_range(2)); dwstrb = 4'($urandom);
      end
      ireq = pend_i;
      dreq = pend_d;
      if (pend_i && $urandom_range(24) == 0) begin ireq = 1'b0; pend_i = 1'b0; end
      if (pend_d && $urandom_range(24) == 0) begin dreq = 1'b0; pend_d = 1'b0; end
      mem_addr_ok = 1'($urandom_range(1));
      if (mq.size() > 0) mem_data_ok = ($urandom_range(2) == 0);
      else mem_data_ok = ($urandom_range(40) == 0);
      mem_rdata = $urandom;
      run_cycle();
      if (hs_i) pend_i = 1'b0;
      if (hs_d) pend_d = 1'b0;
    end

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
